// File: rtl/vmul_wb_router_pkg.sv
// Shared widths, entry layout and packing macro for the multiplier writeback router.
// Falls back to default machine widths when the shared define header is not compiled first.
`ifndef NUM_THREAD
`define NUM_THREAD 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

`define VMUL_WB_PACK(res, msk, idx, wid, wvd, wxd) {res, msk, idx, wid, wvd, wxd}

package vmul_wb_router_pkg;

  localparam int NUM_THREAD = `NUM_THREAD;
  localparam int XLEN       = `XLEN;
  localparam int DEPTH_WARP = `DEPTH_WARP;
  localparam int RESULT_W   = NUM_THREAD * XLEN;
  localparam int IDXW_W     = `REGIDX_WIDTH + `REGEXT_WIDTH;

  typedef struct packed {
    logic [RESULT_W-1:0]   result;
    logic [NUM_THREAD-1:0] mask;
    logic [IDXW_W-1:0]     reg_idxw;
    logic [DEPTH_WARP-1:0] wid;
    logic                  wvd;
    logic                  wxd;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/vmul_wb_router_wb_sync_fifo.sv
// Generic synchronous FIFO with a combinational head read port.
// A full FIFO refuses pushes even when the head pops in the same cycle.
module wb_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_data_o = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vmul_wb_router.sv
// Buffers completed multiplier results and routes each one to the vector
// and/or scalar writeback port, holding an entry until every target has taken it.
module vmul_wb_router
  import vmul_wb_router_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [RESULT_W-1:0]   result_i,
  input  logic [NUM_THREAD-1:0] mask_i,
  input  logic [IDXW_W-1:0]     ctrl_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0] ctrl_wid_i,
  input  logic                  ctrl_wvd_i,
  input  logic                  ctrl_wxd_i,
  output logic                  out_v_valid_o,
  input  logic                  out_v_ready_i,
  output logic [RESULT_W-1:0]   wb_v_data_o,
  output logic [NUM_THREAD-1:0] wb_v_mask_o,
  output logic [IDXW_W-1:0]     wb_v_reg_idxw_o,
  output logic [DEPTH_WARP-1:0] wb_v_wid_o,
  output logic                  out_x_valid_o,
  input  logic                  out_x_ready_i,
  output logic [XLEN-1:0]       wb_x_data_o,
  output logic [IDXW_W-1:0]     wb_x_reg_idxw_o,
  output logic [DEPTH_WARP-1:0] wb_x_wid_o
);

  wb_entry_t push_entry;
  wb_entry_t head;
  logic      full, empty, pop;
  logic      v_fire, x_fire;
  logic      v_done_q, v_done_d;
  logic      x_done_q, x_done_d;

  assign push_entry = `VMUL_WB_PACK(result_i, mask_i, ctrl_reg_idxw_i, ctrl_wid_i,
                                    ctrl_wvd_i, ctrl_wxd_i);
  assign in_ready_o = !full;

  wb_sync_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_valid_i),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_data_o (head)
  );

  assign wb_v_data_o     = head.result;
  assign wb_v_mask_o     = head.mask;
  assign wb_v_reg_idxw_o = head.reg_idxw;
  assign wb_v_wid_o      = head.wid;
  assign wb_x_data_o     = head.result[XLEN-1:0];
  assign wb_x_reg_idxw_o = head.reg_idxw;
  assign wb_x_wid_o      = head.wid;

  // A port that already took the head stays quiet until the other target finishes.
  always_comb begin
    out_v_valid_o = !empty && head.wvd && !v_done_q;
    out_x_valid_o = !empty && head.wxd && !x_done_q;
    v_fire        = out_v_valid_o && out_v_ready_i;
    x_fire        = out_x_valid_o && out_x_ready_i;
    pop           = !empty && (!head.wvd || v_done_q || v_fire)
                           && (!head.wxd || x_done_q || x_fire);
    v_done_d      = v_done_q;
    x_done_d      = x_done_q;
    if (pop) begin
      v_done_d = 1'b0;
      x_done_d = 1'b0;
    end else begin
      if (v_fire) v_done_d = 1'b1;
      if (x_fire) x_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_done_q <= 1'b0;
      x_done_q <= 1'b0;
    end else begin
      v_done_q <= v_done_d;
      x_done_q <= x_done_d;
    end
  end

endmodule

// File: tb/tb_vmul_wb_router.sv
// Scoreboard bench for vmul_wb_router: expected writebacks are queued on accepted
// pushes and checked as each port fires, alongside directed timing checks.
module tb_vmul_wb_router;
  import vmul_wb_router_pkg::*;

  typedef struct {
    logic [RESULT_W-1:0]   data;
    logic [NUM_THREAD-1:0] mask;
    logic [IDXW_W-1:0]     idx;
    logic [DEPTH_WARP-1:0] wid;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid_i = 1'b0;
  logic                  in_ready_o;
  logic [RESULT_W-1:0]   result_i = '0;
  logic [NUM_THREAD-1:0] mask_i = '0;
  logic [IDXW_W-1:0]     ctrl_reg_idxw_i = '0;
  logic [DEPTH_WARP-1:0] ctrl_wid_i = '0;
  logic                  ctrl_wvd_i = 1'b0;
  logic                  ctrl_wxd_i = 1'b0;
  logic                  out_v_valid_o;
  logic                  out_v_ready_i = 1'b0;
  logic [RESULT_W-1:0]   wb_v_data_o;
  logic [NUM_THREAD-1:0] wb_v_mask_o;
  logic [IDXW_W-1:0]     wb_v_reg_idxw_o;
  logic [DEPTH_WARP-1:0] wb_v_wid_o;
  logic                  out_x_valid_o;
  logic                  out_x_ready_i = 1'b0;
  logic [XLEN-1:0]       wb_x_data_o;
  logic [IDXW_W-1:0]     wb_x_reg_idxw_o;
  logic [DEPTH_WARP-1:0] wb_x_wid_o;

  int   total = 0;
  int   bad = 0;
  int   vFires = 0;
  int   xFires = 0;
  exp_t vq[$];
  exp_t xq[$];

  vmul_wb_router #(.FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .result_i        (result_i),
    .mask_i          (mask_i),
    .ctrl_reg_idxw_i (ctrl_reg_idxw_i),
    .ctrl_wid_i      (ctrl_wid_i),
    .ctrl_wvd_i      (ctrl_wvd_i),
    .ctrl_wxd_i      (ctrl_wxd_i),
    .out_v_valid_o   (out_v_valid_o),
    .out_v_ready_i   (out_v_ready_i),
    .wb_v_data_o     (wb_v_data_o),
    .wb_v_mask_o     (wb_v_mask_o),
    .wb_v_reg_idxw_o (wb_v_reg_idxw_o),
    .wb_v_wid_o      (wb_v_wid_o),
    .out_x_valid_o   (out_x_valid_o),
    .out_x_ready_i   (out_x_ready_i),
    .wb_x_data_o     (wb_x_data_o),
    .wb_x_reg_idxw_o (wb_x_reg_idxw_o),
    .wb_x_wid_o      (wb_x_wid_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [RESULT_W-1:0] got,
                             input logic [RESULT_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one entry and holds it until the router accepts it (bounded wait).
  task automatic applyStimulus(input logic [XLEN-1:0] lane0, input logic [NUM_THREAD-1:0] msk,
                               input logic [IDXW_W-1:0] idx, input logic [DEPTH_WARP-1:0] wid,
                               input logic wvd, input logic wxd);
    bit acc = 1'b0;
    result_i        = {32'h3333_0000 | lane0, 32'h2222_0000 | lane0,
                       32'h1111_0000 | lane0, lane0};
    mask_i          = msk;
    ctrl_reg_idxw_i = idx;
    ctrl_wid_i      = wid;
    ctrl_wvd_i      = wvd;
    ctrl_wxd_i      = wxd;
    in_valid_i      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = in_ready_o;
      tick();
      if (acc) break;
    end
    in_valid_i = 1'b0;
    if (!acc) checkOutput("push_timeout", 0, 1);
  endtask

  // Scoreboard: record accepted pushes, compare each port transfer with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      vq.delete();
      xq.delete();
    end else begin
      if (out_v_valid_o && out_v_ready_i) begin
        vFires++;
        if (vq.size() == 0) checkOutput("v_unexpected", 1, 0);
        else begin
          e = vq.pop_front();
          checkOutput("v_data", wb_v_data_o, e.data);
          checkOutput("v_mask", RESULT_W'(wb_v_mask_o), RESULT_W'(e.mask));
          checkOutput("v_idx", RESULT_W'(wb_v_reg_idxw_o), RESULT_W'(e.idx));
          checkOutput("v_wid", RESULT_W'(wb_v_wid_o), RESULT_W'(e.wid));
        end
      end
      if (out_x_valid_o && out_x_ready_i) begin
        xFires++;
        if (xq.size() == 0) checkOutput("x_unexpected", 1, 0);
        else begin
          e = xq.pop_front();
          checkOutput("x_data", RESULT_W'(wb_x_data_o), RESULT_W'(e.data[XLEN-1:0]));
          checkOutput("x_idx", RESULT_W'(wb_x_reg_idxw_o), RESULT_W'(e.idx));
          checkOutput("x_wid", RESULT_W'(wb_x_wid_o), RESULT_W'(e.wid));
        end
      end
      if (in_valid_i && in_ready_o) begin
        e.data = result_i;
        e.mask = mask_i;
        e.idx  = ctrl_reg_idxw_i;
        e.wid  = ctrl_wid_i;
        if (ctrl_wvd_i) vq.push_back(e);
        if (ctrl_wxd_i) xq.push_back(e);
      end
    end
  end

  initial begin
    int v0, x0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_v_valid", RESULT_W'(out_v_valid_o), 0);
    checkOutput("rst_x_valid", RESULT_W'(out_x_valid_o), 0);
    checkOutput("rst_in_ready", RESULT_W'(in_ready_o), 1);
    checkOutput("rst_v_data", wb_v_data_o, 0);

    // Vector-only entry with ready high.
    out_v_ready_i = 1'b1;
    applyStimulus(32'h0000_0005, 4'hF, 8'h11, 3'd1, 1'b1, 1'b0);
    checkOutput("s1_v_valid", RESULT_W'(out_v_valid_o), 1);
    checkOutput("s1_x_valid", RESULT_W'(out_x_valid_o), 0);
    checkOutput("s1_lane0", RESULT_W'(wb_v_data_o[31:0]), 5);
    tick();
    checkOutput("s1_popped", RESULT_W'(out_v_valid_o), 0);
    checkOutput("s1_x_quiet", RESULT_W'(out_x_valid_o), 0);
    out_v_ready_i = 1'b0;

    // Scalar entry held under back-pressure.
    x0 = xFires;
    applyStimulus(32'hFFFF_FFFE, 4'h3, 8'h22, 3'd2, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("s2_x_hold", RESULT_W'(out_x_valid_o), 1);
      checkOutput("s2_x_stable", RESULT_W'(wb_x_data_o), RESULT_W'(32'hFFFF_FFFE));
      tick();
    end
    out_x_ready_i = 1'b1;
    tick();
    out_x_ready_i = 1'b0;
    checkOutput("s2_x_done", RESULT_W'(out_x_valid_o), 0);
    checkOutput("s2_x_count", RESULT_W'(xFires - x0), 1);

    // Dual-target entry: scalar first, vector three cycles later.
    v0 = vFires;
    x0 = xFires;
    out_x_ready_i = 1'b1;
    applyStimulus(32'h0000_00A7, 4'h5, 8'h33, 3'd3, 1'b1, 1'b1);
    checkOutput("s3_x_c1", RESULT_W'(out_x_valid_o), 1);
    checkOutput("s3_v_c1", RESULT_W'(out_v_valid_o), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("s3_x_low", RESULT_W'(out_x_valid_o), 0);
      checkOutput("s3_v_wait", RESULT_W'(out_v_valid_o), 1);
    end
    out_v_ready_i = 1'b1;
    tick();
    checkOutput("s3_v_after", RESULT_W'(out_v_valid_o), 0);
    checkOutput("s3_x_after", RESULT_W'(out_x_valid_o), 0);
    checkOutput("s3_v_count", RESULT_W'(vFires - v0), 1);
    checkOutput("s3_x_count", RESULT_W'(xFires - x0), 1);
    out_v_ready_i = 1'b0;
    out_x_ready_i = 1'b0;

    // Fill the FIFO, hold a third entry, then drain in order.
    v0 = vFires;
    applyStimulus(32'h0000_0041, 4'h1, 8'h41, 3'd4, 1'b1, 1'b0);
    applyStimulus(32'h0000_0042, 4'h2, 8'h42, 3'd5, 1'b1, 1'b0);
    checkOutput("s4_full", RESULT_W'(in_ready_o), 0);
    result_i        = {96'h0, 32'h0000_0043};
    mask_i          = 4'h4;
    ctrl_reg_idxw_i = 8'h43;
    ctrl_wid_i      = 3'd6;
    ctrl_wvd_i      = 1'b1;
    ctrl_wxd_i      = 1'b0;
    in_valid_i      = 1'b1;
    tick();
    tick();
    checkOutput("s4_held", RESULT_W'(in_ready_o), 0);
    checkOutput("s4_head", RESULT_W'(wb_v_data_o[31:0]), RESULT_W'(32'h0000_0041));
    out_v_ready_i = 1'b1;
    applyStimulus(32'h0000_0043, 4'h4, 8'h43, 3'd6, 1'b1, 1'b0);
    repeat (4) tick();
    checkOutput("s4_ready_back", RESULT_W'(in_ready_o), 1);
    checkOutput("s4_drained", RESULT_W'(out_v_valid_o), 0);
    checkOutput("s4_v_count", RESULT_W'(vFires - v0), 3);

    // Entry with no targets drops silently; the next shows immediately after.
    applyStimulus(32'h0000_0050, 4'hF, 8'h50, 3'd0, 1'b0, 1'b0);
    checkOutput("s5_no_v", RESULT_W'(out_v_valid_o), 0);
    checkOutput("s5_no_x", RESULT_W'(out_x_valid_o), 0);
    applyStimulus(32'h0000_0051, 4'h9, 8'h51, 3'd1, 1'b1, 1'b0);
    checkOutput("s5_v_next", RESULT_W'(out_v_valid_o), 1);
    checkOutput("s5_data", RESULT_W'(wb_v_data_o[31:0]), RESULT_W'(32'h0000_0051));
    tick();
    out_v_ready_i = 1'b0;

    // Reset with a full FIFO and a half-sent dual entry.
    applyStimulus(32'h0000_0061, 4'hF, 8'h61, 3'd2, 1'b1, 1'b1);
    applyStimulus(32'h0000_0062, 4'hF, 8'h62, 3'd3, 1'b1, 1'b0);
    out_x_ready_i = 1'b1;
    tick();
    out_x_ready_i = 1'b0;
    checkOutput("s6_half_x", RESULT_W'(out_x_valid_o), 0);
    checkOutput("s6_half_v", RESULT_W'(out_v_valid_o), 1);
    checkOutput("s6_full", RESULT_W'(in_ready_o), 0);
    rst = 1'b1;
    tick();
    checkOutput("s6_rst_v", RESULT_W'(out_v_valid_o), 0);
    checkOutput("s6_rst_x", RESULT_W'(out_x_valid_o), 0);
    checkOutput("s6_rst_ready", RESULT_W'(in_ready_o), 1);
    checkOutput("s6_rst_data", wb_v_data_o, 0);
    checkOutput("s6_rst_xdata", RESULT_W'(wb_x_data_o), 0);
    rst = 1'b0;
    out_v_ready_i = 1'b1;
    applyStimulus(32'h0000_0005, 4'hF, 8'h11, 3'd1, 1'b1, 1'b0);
    checkOutput("s6_again_v", RESULT_W'(out_v_valid_o), 1);
    checkOutput("s6_again_x", RESULT_W'(out_x_valid_o), 0);
    tick();
    checkOutput("s6_again_pop", RESULT_W'(out_v_valid_o), 0);
    out_v_ready_i = 1'b0;
    tick();

    checkOutput("sb_v_empty", RESULT_W'(vq.size()), 0);
    checkOutput("sb_x_empty", RESULT_W'(xq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vmul_wb_router.md
Name: vmul_wb_router

Overview:
- Downstream of the per-lane vector multiplier/MAC pipeline.
- Captures one warp instruction's completed result per handshake: all lanes' XLEN results plus mask and control.
- Buffers results in a small FIFO.
- Routes each entry to the vector writeback port (wvd), the scalar writeback port (wxd), or both.
- Absorbs writeback back-pressure so the multiplier pipeline only stalls when the FIFO is full.

Parameters:
- FIFO_DEPTH, 2, number of buffered entries; power of two, ≥2.
- Uses the shared define.v macros `NUM_THREAD, `XLEN, `REGIDX_WIDTH, `REGEXT_WIDTH and `DEPTH_WARP.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high; clears all state.
- in_valid_i  in  1  upstream result valid.
- in_ready_o  out  1  router can accept an entry.
- result_i  in  NUM_THREAD*XLEN  lane results; lane k at bits [k*XLEN +: XLEN].
- mask_i  in  NUM_THREAD  active-lane mask.
- ctrl_reg_idxw_i  in  REGIDX_WIDTH+REGEXT_WIDTH  destination register.
- ctrl_wid_i  in  DEPTH_WARP  warp id.
- ctrl_wvd_i  in  1  vector register write.
- ctrl_wxd_i  in  1  scalar register write.
- out_v_valid_o  out  1  vector writeback valid.
- out_v_ready_i  in  1  vector writeback ready.
- wb_v_data_o  out  NUM_THREAD*XLEN  vector data.
- wb_v_mask_o  out  NUM_THREAD  vector write mask.
- wb_v_reg_idxw_o  out  REGIDX_WIDTH+REGEXT_WIDTH  vector destination register.
- wb_v_wid_o  out  DEPTH_WARP  vector warp id.
- out_x_valid_o  out  1  scalar writeback valid.
- out_x_ready_i  in  1  scalar writeback ready.
- wb_x_data_o  out  XLEN  scalar data = lane 0 result.
- wb_x_reg_idxw_o  out  REGIDX_WIDTH+REGEXT_WIDTH  scalar destination register.
- wb_x_wid_o  out  DEPTH_WARP  scalar warp id.

Behaviour:
- Storage:
  - FIFO_DEPTH entries of {result, mask, reg_idxw, wid, wvd, wxd}.
  - Write pointer, read pointer, and occupancy count 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Push:
  - in_ready_o = (count != FIFO_DEPTH). No pop-to-push bypass, so a full FIFO deasserts ready even if the head pops this cycle.
  - Push occurs when in_valid_i && in_ready_o.
- Latency: an entry pushed at edge N presents at the outputs after edge N, when the FIFO was empty; one-cycle minimum.
- Outputs:
  - Combinational from the head entry.
  - out_v_valid_o = !empty && head.wvd && !v_done.
  - out_x_valid_o = !empty && head.wxd && !x_done.
  - Data, mask, idxw and wid outputs show the head entry regardless of valid.
- Sent flags:
  - v_done and x_done registers apply to the head only.
  - v_fire = out_v_valid_o && out_v_ready_i; v_done is set on v_fire when the head does not pop.
  - x_fire and x_done behave the same way on the scalar port.
  - Both flags clear on pop.
- Pop rule: pop = !empty && (!wvd || v_done || v_fire) && (!wxd || x_done || x_fire).
  - Dual-target entry: each port fires exactly once, in any order or simultaneously; the entry pops when the second port completes.
  - Entry with wvd=wxd=0: popped the cycle after it reaches the head; no output valid is asserted.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Valid stability: once asserted, a port's valid and its data stay stable until that port fires.
- Reset:
  - rst high at any time, including mid-transaction, clears pointers, count, flags and all storage to 0.
  - Both output valids are 0 in the cycle after reset is sampled, and all data outputs read 0.
  - in_ready_o is 1 after reset.
  - Partially delivered entries are discarded.
- Mask: passed unchanged on the vector port. The scalar port ignores the mask; lane 0 is always used.

Decomposition:
- Shared package/header additions: entry field widths (RESULT_W = NUM_THREAD*XLEN, IDXW_W = REGIDX_WIDTH+REGEXT_WIDTH) and an entry-packing macro.
- One natural sub-module: wb_sync_fifo, a generic synchronous FIFO with DATA_W and DEPTH parameters, push/pop, full/empty and a head-data read port.
- Routing and flag logic stay in vmul_wb_router.

Test Plan:
1. Reset, then push one entry {wvd=1, wxd=0, lane0=0x00000005, mask=all ones} with out_v_ready_i=1 -> out_v_valid_o=1 one cycle later, data matches, pops; out_x_valid_o stays 0.
2. Push a wxd=1 entry with lane0=0xFFFFFFFE while out_x_ready_i=0 for 5 cycles -> out_x_valid_o held high with wb_x_data_o=0xFFFFFFFE stable; single transfer when ready rises.
3. Push a wvd=wxd=1 entry; x_ready=1 at cycle 1 and v_ready=0 until cycle 4 -> exactly one x transfer at cycle 1, one v transfer at cycle 4, pop at cycle 4; out_x_valid_o low during cycles 2–4.
4. Both readies 0, push 3 entries with FIFO_DEPTH=2 -> in_ready_o=0 after the 2nd push and the 3rd is held; with readies high, entries drain in order and in_ready_o returns to 1.
5. Push a wvd=wxd=0 entry followed by a wvd entry -> no valid for the first, which pops in 1 cycle; the second appears on the vector port the next cycle.
6. Assert rst while the FIFO is full and a dual-target entry is half-sent -> next cycle count=0, both valids 0, in_ready_o=1, data outputs 0; a subsequent push behaves as in scenario 1.
